// File: rtl/datapath_trace_buffer.sv
// Triggered capture buffer snooping CHANNELS x WIDTH datapath result buses; drains oldest-first.
// Optional per-row 16-bit timestamps are enabled by defining TRACE_TIMESTAMP_EN.
module datapath_trace_buffer #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 16,
    localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int ROW_W    = CHANNELS * WIDTH
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [ROW_W-1:0]    SampleIn,
    input  logic                SampleValid,
    input  logic                Arm,
    input  logic [CH_BITS-1:0]  TrigChannel,
    input  logic [WIDTH-1:0]    TrigValue,
    input  logic                ChangeOnly,
    input  logic                RdEn,
    output logic [ROW_W-1:0]    RdData,
    output logic                RdValid,
    output logic [PTR_W:0]      Count,
`ifdef TRACE_TIMESTAMP_EN
    output logic [15:0]         RdTimestamp,
`endif
    output logic [1:0]          State
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_LAST  = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W + 1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [CH_BITS:0] CH_LIMIT  = (CH_BITS + 1)'(CHANNELS);

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 store_s;
    logic                 clear_s;
    logic                 pop_s;
    logic                 trig_hit_s;
    logic                 row_differs_s;
    logic [CH_BITS-1:0]   trig_sel_s;
    logic [WIDTH-1:0]     ch_s [CHANNELS];

    logic [ROW_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W:0]       count_r;
    logic [ROW_W-1:0]     last_row_r;
    logic [ROW_W-1:0]     rd_data_r;
    logic                 rd_valid_r;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign ch_s[k] = SampleIn[k*WIDTH +: WIDTH];
    end

    // Out-of-range channel selects fall back to channel 0
    assign trig_sel_s    = ({1'b0, TrigChannel} < CH_LIMIT) ? TrigChannel : CH_BITS'(0);
    assign trig_hit_s    = SampleValid && (ch_s[trig_sel_s] == TrigValue);
    assign row_differs_s = (SampleIn != last_row_r);

    // Capture state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes; Arm outranks trigger and store
    always_comb begin
        state_nxt_s = state_r;
        store_s     = 1'b0;
        clear_s     = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Arm) begin
                    clear_s     = 1'b1;
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (Arm) begin
                    clear_s     = 1'b1;
                    state_nxt_s = ST_ARMED;
                end else if (trig_hit_s) begin
                    store_s     = 1'b1;
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (Arm) begin
                    clear_s     = 1'b1;
                    state_nxt_s = ST_ARMED;
                end else if (SampleValid && (!ChangeOnly || row_differs_s)) begin
                    store_s     = 1'b1;
                    state_nxt_s = (count_r == CNT_LAST) ? ST_DONE : ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (RdEn && (count_r != CNT_ZERO)) begin
                    pop_s       = 1'b1;
                    state_nxt_s = (count_r == CNT_ONE) ? ST_IDLE : ST_DONE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pointers, occupancy, last-stored row and registered read port
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            last_row_r <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            if (clear_s) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
                count_r  <= CNT_ZERO;
            end else if (store_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_ONE;
                count_r    <= count_r + CNT_ONE;
                last_row_r <= SampleIn;
            end else if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                count_r    <= count_r - CNT_ONE;
                rd_data_r  <= mem[rd_ptr_r];
                rd_valid_r <= 1'b1;
            end
        end
    end

    // Row storage; contents are never cleared, occupancy gates every read
    always_ff @(posedge Clk) begin
        if (store_s) begin
            mem[wr_ptr_r] <= SampleIn;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_r;
    logic [15:0] ts_mem [DEPTH];
    logic [15:0] rd_ts_r;

    // Free-running cycle stamp
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ts_r <= 16'h0000;
        end else begin
            ts_r <= ts_r + 16'h0001;
        end
    end

    // Stamp captured alongside each stored row
    always_ff @(posedge Clk) begin
        if (store_s) begin
            ts_mem[wr_ptr_r] <= ts_r;
        end
    end

    // Timestamp read register, same timing as the row read
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ts_r <= 16'h0000;
        end else if (pop_s) begin
            rd_ts_r <= ts_mem[rd_ptr_r];
        end
    end

    assign RdTimestamp = rd_ts_r;
`endif

    assign RdData  = rd_data_r;
    assign RdValid = rd_valid_r;
    assign Count   = count_r;
    assign State   = state_r;

endmodule

// File: tb/tb_datapath_trace_buffer.sv
// Self-checking bench for datapath_trace_buffer: directed scenarios plus randomized traffic
// against a queue-based behavioural model. Timestamp checks build when TRACE_TIMESTAMP_EN is set.
module tb_datapath_trace_buffer;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 16;
    localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int RW       = CHANNELS * WIDTH;

    logic               Clk = 1'b0;
    logic               Reset;
    logic [RW-1:0]      SampleIn;
    logic               SampleValid;
    logic               Arm;
    logic [CH_BITS-1:0] TrigChannel;
    logic [WIDTH-1:0]   TrigValue;
    logic               ChangeOnly;
    logic               RdEn;
    logic [RW-1:0]      RdData;
    logic               RdValid;
    logic [CW-1:0]      Count;
    logic [1:0]         State;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]        RdTimestamp;
`endif

    datapath_trace_buffer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .SampleIn(SampleIn), .SampleValid(SampleValid),
        .Arm(Arm), .TrigChannel(TrigChannel), .TrigValue(TrigValue),
        .ChangeOnly(ChangeOnly), .RdEn(RdEn), .RdData(RdData), .RdValid(RdValid),
        .Count(Count),
`ifdef TRACE_TIMESTAMP_EN
        .RdTimestamp(RdTimestamp),
`endif
        .State(State)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode uses the externally visible State codes, rows live in a queue
    int              m_mode;
    logic [RW-1:0]   m_q[$];
    logic [15:0]     m_tq[$];
    logic [RW-1:0]   m_last;
    logic [RW-1:0]   m_rd_data;
    logic            m_rd_valid;
    logic [15:0]     m_ts;
    logic [15:0]     m_rd_ts;

    task automatic chk_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] mk_row(input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1);
        return {c1, c0};
    endfunction

    function automatic logic [WIDTH-1:0] chan_of(input logic [RW-1:0] row, input int k);
        return row[k*WIDTH +: WIDTH];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_tq.delete();
        m_last = '0; m_rd_data = '0; m_rd_valid = 1'b0; m_ts = 16'h0000; m_rd_ts = 16'h0000;
    endtask

    task automatic model_edge();
        int sel;
        sel = (int'(TrigChannel) < CHANNELS) ? int'(TrigChannel) : 0;
        m_rd_valid = 1'b0;
        case (m_mode)
            0: if (Arm) begin m_mode = 1; m_q.delete(); m_tq.delete(); end
            1: begin
                if (Arm) begin
                    m_q.delete(); m_tq.delete();
                end else if (SampleValid && chan_of(SampleIn, sel) == TrigValue) begin
                    m_q.push_back(SampleIn); m_tq.push_back(m_ts); m_last = SampleIn; m_mode = 2;
                end
            end
            2: begin
                if (Arm) begin
                    m_q.delete(); m_tq.delete(); m_mode = 1;
                end else if (SampleValid && (!ChangeOnly || SampleIn != m_last)) begin
                    m_q.push_back(SampleIn); m_tq.push_back(m_ts); m_last = SampleIn;
                    if (m_q.size() == DEPTH) m_mode = 3;
                end
            end
            3: begin
                if (RdEn && m_q.size() > 0) begin
                    m_rd_data = m_q.pop_front(); m_rd_ts = m_tq.pop_front(); m_rd_valid = 1'b1;
                    if (m_q.size() == 0) m_mode = 0;
                end
            end
            default: m_mode = 0;
        endcase
        m_ts = m_ts + 16'h0001;
    endtask

    task automatic compare_all();
        chk_eq("state",   RW'(State),   RW'(m_mode));
        chk_eq("count",   RW'(Count),   RW'(m_q.size()));
        chk_eq("rdvalid", RW'(RdValid), RW'(m_rd_valid));
        chk_eq("rddata",  RdData,       m_rd_data);
`ifdef TRACE_TIMESTAMP_EN
        chk_eq("rdts",    RW'(RdTimestamp), RW'(m_rd_ts));
`endif
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic quiet_inputs();
        SampleIn = '0; SampleValid = 1'b0; Arm = 1'b0; TrigChannel = '0;
        TrigValue = '0; ChangeOnly = 1'b0; RdEn = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #3 Reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    task automatic arm_pulse();
        Arm = 1'b1; cycle(); Arm = 1'b0;
    endtask

    task automatic drain_all();
        RdEn = 1'b1;
        for (int i = 0; i < DEPTH + 2 && Count != '0; i++) cycle();
        RdEn = 1'b0;
        chk_eq("drain_count", RW'(Count), RW'(0));
    endtask

    initial begin
        Reset = 1'b1;
        quiet_inputs();
        do_reset();
        chk_eq("rst_state", RW'(State), RW'(0));
        chk_eq("rst_count", RW'(Count), RW'(0));

        // Ramp on channel 1, trigger at 0x10
        arm_pulse();
        TrigChannel = CH_BITS'(1); TrigValue = 32'h10; SampleValid = 1'b1;
        for (int v = 12; v <= 47; v++) begin
            SampleIn = mk_row($urandom, WIDTH'(v));
            cycle();
            if (v < 16) chk_eq("ramp_pre_count", RW'(Count), RW'(0));
        end
        SampleValid = 1'b0;
        chk_eq("ramp_state", RW'(State), RW'(3));
        chk_eq("ramp_count", RW'(Count), RW'(16));

        RdEn = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            chk_eq("ramp_rv", RW'(RdValid), RW'(1));
            chk_eq("ramp_rd", RW'(chan_of(RdData, 1)), RW'(32'h10 + i));
        end
        chk_eq("ramp_idle", RW'(State), RW'(0));
        cycle();
        chk_eq("ramp_17th_rv", RW'(RdValid), RW'(0));
        RdEn = 1'b0;

        // Async reset mid-capture at Count 5
        arm_pulse();
        TrigChannel = '0; TrigValue = 32'hA5; SampleValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            SampleIn = mk_row((i == 0) ? 32'hA5 : 32'(i), 32'h77);
            cycle();
        end
        SampleValid = 1'b0;
        chk_eq("pre_rst_count", RW'(Count), RW'(5));
        #3 Reset = 1'b1;
        #1;
        chk_eq("arst_state", RW'(State), RW'(0));
        chk_eq("arst_count", RW'(Count), RW'(0));
        chk_eq("arst_rv", RW'(RdValid), RW'(0));
        chk_eq("arst_rd", RdData, '0);
        #2 Reset = 1'b0;
        model_reset();

        // ChangeOnly: A,A,B,B,B,(gap),C
        arm_pulse();
        ChangeOnly = 1'b1; TrigChannel = '0; TrigValue = 32'hA;
        SampleValid = 1'b1;
        SampleIn = mk_row(32'hA, 32'h1); cycle(); cycle();
        SampleIn = mk_row(32'hB, 32'h1); cycle(); cycle(); cycle();
        SampleValid = 1'b0; SampleIn = mk_row(32'hC, 32'h9); cycle(); cycle();
        SampleValid = 1'b1; SampleIn = mk_row(32'hC, 32'h1); cycle();
        SampleValid = 1'b0;
        chk_eq("co_count", RW'(Count), RW'(3));
        SampleValid = 1'b1;
        for (int i = 0; i < DEPTH - 3; i++) begin
            SampleIn = mk_row(32'h100 + i, 32'h2); cycle();
        end
        SampleValid = 1'b0; ChangeOnly = 1'b0;
        RdEn = 1'b1;
        cycle(); chk_eq("co_rd0", RdData, mk_row(32'hA, 32'h1));
        cycle(); chk_eq("co_rd1", RdData, mk_row(32'hB, 32'h1));
        cycle(); chk_eq("co_rd2", RdData, mk_row(32'hC, 32'h1));
        drain_all();

        // Arm together with a valid sample at Count 7
        arm_pulse();
        TrigChannel = '0; TrigValue = 32'h55; SampleValid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            SampleIn = mk_row((i == 0) ? 32'h55 : 32'(i), 32'h3); cycle();
        end
        chk_eq("arm7_count", RW'(Count), RW'(7));
        Arm = 1'b1; SampleIn = mk_row(32'h55, 32'h4); cycle(); Arm = 1'b0;
        chk_eq("rearm_state", RW'(State), RW'(1));
        chk_eq("rearm_count", RW'(Count), RW'(0));
        SampleIn = mk_row(32'h55, 32'hBEEF); cycle();
        for (int i = 1; i < DEPTH; i++) begin
            SampleIn = mk_row(32'(i), 32'h5); cycle();
        end
        SampleValid = 1'b0;
        RdEn = 1'b1; cycle(); RdEn = 1'b0;
        chk_eq("rearm_rd0", RdData, mk_row(32'h55, 32'hBEEF));
        drain_all();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) begin
                ChangeOnly = 1'($urandom_range(0, 1));
                TrigValue  = WIDTH'($urandom_range(0, 3));
            end
            Arm         = ($urandom_range(0, 59) == 0);
            SampleValid = ($urandom_range(0, 3) != 0);
            SampleIn    = mk_row(WIDTH'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 3)));
            TrigChannel = CH_BITS'($urandom);
            RdEn        = 1'($urandom_range(0, 1));
            cycle();
        end
        quiet_inputs();

`ifdef TRACE_TIMESTAMP_EN
        // Trigger with stamp 5 after reset release
        do_reset();
        repeat (4) cycle();
        arm_pulse();
        TrigValue = 32'h5A; SampleValid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            SampleIn = mk_row((i == 0) ? 32'h5A : 32'(i), 32'h0); cycle();
        end
        SampleValid = 1'b0; RdEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(); chk_eq("ts_seq", RW'(RdTimestamp), RW'(5 + i));
        end
        drain_all();

        // Counter wrap across captured rows
        while (m_ts != 16'hFFFD) cycle();
        arm_pulse();
        TrigValue = 32'h5A; SampleValid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            SampleIn = mk_row((i == 0) ? 32'h5A : 32'(i), 32'h0); cycle();
        end
        SampleValid = 1'b0; RdEn = 1'b1;
        cycle(); chk_eq("ts_wrap0", RW'(RdTimestamp), RW'(16'hFFFE));
        cycle(); chk_eq("ts_wrap1", RW'(RdTimestamp), RW'(16'hFFFF));
        cycle(); chk_eq("ts_wrap2", RW'(RdTimestamp), RW'(16'h0000));
        drain_all();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_trace_buffer.md
Name: datapath_trace_buffer

Overview:
- Parametrised, triggered capture buffer for multi-channel datapath observation outputs, e.g. Output1/Output2 of Top_Datapath; generalises them to CHANNELS x WIDTH.
- Synthesisable companion to the datapath testbenches; sits beside the datapath and snoops result buses.
- Once armed, waits for a trigger value on a selected channel, records up to DEPTH rows of all channels, then drains them through a registered read port.

Parameters:
WIDTH, 32, bits per channel
CHANNELS, 2, number of snooped channels (>=1)
DEPTH, 16, capture rows; power of 2, >=2
CH_BITS, (CHANNELS>1 ? $clog2(CHANNELS) : 1), localparam, channel-select width

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state
SampleIn  input  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
SampleValid  input  1  SampleIn qualifies this cycle
Arm  input  1  start or restart a capture
TrigChannel  input  CH_BITS  channel compared for trigger; out-of-range treated as channel 0
TrigValue  input  WIDTH  trigger match value
ChangeOnly  input  1  1 = store a row only if it differs from the last stored row
RdEn  input  1  pop request
RdData  output  CHANNELS*WIDTH  registered oldest row
RdValid  output  1  RdData updated this cycle
Count  output  $clog2(DEPTH)+1  rows held
State  output  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE

Behaviour:
- Reset (async, any state): State=00, Count=0, RdValid=0, RdData=0, write/read pointers=0, last-row register=0.
- IDLE: samples ignored. Arm=1 -> ARMED.
- ARMED: trigger = SampleValid & (channel TrigChannel == TrigValue). On trigger, store the row at entry 0, Count=1 -> CAPTURE. ChangeOnly does not suppress the trigger row.
- CAPTURE: each SampleValid cycle stores the row at write pointer, Count+1. With ChangeOnly=1, store only if SampleIn != last stored row. Store making Count==DEPTH -> DONE in the same edge; no further stores.
- Arm in ARMED or CAPTURE: clear Count and pointers -> ARMED. Arm has priority over a simultaneous trigger or store. Arm in DONE is ignored.
- DONE: RdEn with Count>0 gives RdData=oldest row and RdValid=1 on the next edge; read pointer+1, Count-1. RdValid is a 1-cycle pulse; RdData holds until the next pop.
- Pop that makes Count 0 -> IDLE on the same edge.
- RdEn is ignored outside DONE or when Count==0; RdValid stays 0.
- Back-to-back RdEn on consecutive cycles: one row per cycle, no bubbles.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Memory is not cleared by reset; Count gates all reads.
- Latency: trigger row is visible in Count 1 cycle after the trigger edge. Read latency is 1 cycle.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined: 16-bit free-running counter, reset to 0, +1 every cycle, wraps 0xFFFF->0x0000. Counter value in a row's store cycle is kept with the row. Extra output RdTimestamp [15:0] is registered alongside RdData with identical timing and reset value 0.
- Undefined: no counter, no storage, no RdTimestamp port.

Test Plan:
- Reset asserted mid-CAPTURE with Count=5, async between edges -> State=00, Count=0, RdValid=0, RdData=0 immediately, before the next edge.
- Arm; TrigChannel=1, TrigValue=0x10; ch1 ramps 0x0C..0x2F, SampleValid=1 -> no store before 0x10; rows ch1=0x10..0x1F; State=11, Count=16; samples 0x20+ ignored.
- From the previous DONE, 16 consecutive RdEn -> RdValid every cycle, RdData ch1=0x10..0x1F in order, Count 16->0, State=00 after the last pop; 17th RdEn gives no RdValid.
- ChangeOnly=1, trigger on A; rows A,A,B,B,B,C, SampleValid low for 2 cycles between B and C -> Count=3, readout A,B,C.
- In CAPTURE with Count=7, Arm pulsed in the same cycle as a valid sample -> State=01, Count=0, sample not stored; next trigger restarts at entry 0.
- TRACE_TIMESTAMP_EN defined, trigger 5 cycles after Reset release with SampleValid=1 every cycle -> readout timestamps 5,6,7,...; pre-load the counter to 0xFFFE -> 0xFFFE,0xFFFF,0x0000.
